boothmul_radix4: RTL and testbench

Radix-4 (modified) Booth sequential multiplier and the parametrised successor to the radix-2 control-loop multiplier. Each operand can be signed or unsigned, independently, and the mode is selected per operation. Each cycle retires two multiplier bits, so the latency is roughly half that of the radix-2 block. It keeps the same `arm`/`fin` handshake, so it can replace the old block in the control loop. It also adds abort-on-disarm and a result register that is only written when a multiplication completes.

---
 rtl/boothmul_radix4.sv | 105 ++++++++++
 tb/tb_boothmul_radix4.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/boothmul_radix4.sv
// Radix-4 (modified Booth) sequential multiplier, two multiplier bits per cycle.
// Per-operation signed/unsigned operands, arm/fin handshake, abort on disarm.
module boothmul_radix4 #(
  parameter int A1_LEN  = 32,
  parameter int A2_LEN  = 32,
  parameter int CNT_SIZ = 6
) (
  input  logic                     clk,
  input  logic                     rst_L,
  input  logic                     arm,
  input  logic                     a1_signed,
  input  logic                     a2_signed,
  input  logic [A1_LEN-1:0]        a1,
  input  logic [A2_LEN-1:0]        a2,
  output logic [A1_LEN+A2_LEN-1:0] outn,
  output logic                     fin
);

  localparam int E    = (A2_LEN % 2 == 0) ? A2_LEN + 2 : A2_LEN + 1;
  localparam int ITER = E / 2;
  // One bit beyond the +/-2A range: the running upper half plus a new
  // partial product can reach about 8/3 of |A| before the shift.
  localparam int UW   = A1_LEN + 3;
  localparam int AW   = UW + E + 1;
  localparam int PW   = A1_LEN + A2_LEN;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_reg;
  logic [UW-1:0]      mcand_reg;
  logic [AW-1:0]      acc_reg;
  logic [CNT_SIZ-1:0] cnt_reg;
  logic [PW-1:0]      outn_reg;
  logic               fin_reg;

  logic [UW-1:0]      a1_ext;
  logic [E-1:0]       a2_ext;
  logic [UW-1:0]      pp;
  logic [UW-1:0]      upper_sum;
  logic [AW-1:0]      acc_next;

  assign a1_ext = {{3{a1_signed & a1[A1_LEN-1]}}, a1};
  assign a2_ext = {{(E-A2_LEN){a2_signed & a2[A2_LEN-1]}}, a2};

  // acc_reg[2:0] is the recoding window {m[i+1], m[i], m[i-1]}.
  always_comb begin
    pp = '0;
    case (acc_reg[2:0])
      3'b001, 3'b010: pp = mcand_reg;
      3'b011:         pp = mcand_reg << 1;
      3'b100:         pp = -(mcand_reg << 1);
      3'b101, 3'b110: pp = -mcand_reg;
      default:        pp = '0;
    endcase
    upper_sum = acc_reg[AW-1 -: UW] + pp;
    acc_next  = {{2{upper_sum[UW-1]}}, upper_sum, acc_reg[E:2]};
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_reg <= IDLE;
      mcand_reg <= '0;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      outn_reg  <= '0;
      fin_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          fin_reg <= 1'b0;
          if (arm) begin
            mcand_reg <= a1_ext;
            acc_reg   <= {{UW{1'b0}}, a2_ext, 1'b0};
            cnt_reg   <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          if (!arm) begin
            state_reg <= IDLE;
          end else begin
            acc_reg <= acc_next;
            cnt_reg <= cnt_reg + CNT_SIZ'(1);
            if (cnt_reg == CNT_SIZ'(ITER - 1)) begin
              outn_reg  <= acc_next[PW:1];
              fin_reg   <= 1'b1;
              state_reg <= DONE;
            end
          end
        end
        DONE: begin
          if (!arm) begin
            fin_reg   <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign outn = outn_reg;
  assign fin  = fin_reg;

endmodule

// File: tb/tb_boothmul_radix4.sv
// Directed and random checks of boothmul_radix4 in 8x8, 32x32 and 9x7 builds.
module tb_boothmul_radix4;

  logic        clk = 1'b0;
  logic        rst_L;
  logic        sg1, sg2;

  logic        arm8;
  logic [7:0]  a1_8, a2_8;
  logic [15:0] outn8;
  logic        fin8;

  logic        arm32;
  logic [31:0] a1_32, a2_32;
  logic [63:0] outn32;
  logic        fin32;

  logic        arm97;
  logic [8:0]  a1_97;
  logic [6:0]  a2_97;
  logic [15:0] outn97;
  logic        fin97;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  always #5 clk = ~clk;

  boothmul_radix4 #(.A1_LEN(8), .A2_LEN(8), .CNT_SIZ(4)) dut8 (
    .clk(clk), .rst_L(rst_L), .arm(arm8), .a1_signed(sg1), .a2_signed(sg2),
    .a1(a1_8), .a2(a2_8), .outn(outn8), .fin(fin8));

  boothmul_radix4 #(.A1_LEN(32), .A2_LEN(32), .CNT_SIZ(6)) dut32 (
    .clk(clk), .rst_L(rst_L), .arm(arm32), .a1_signed(sg1), .a2_signed(sg2),
    .a1(a1_32), .a2(a2_32), .outn(outn32), .fin(fin32));

  boothmul_radix4 #(.A1_LEN(9), .A2_LEN(7), .CNT_SIZ(4)) dut97 (
    .clk(clk), .rst_L(rst_L), .arm(arm97), .a1_signed(sg1), .a2_signed(sg2),
    .a1(a1_97), .a2(a2_97), .outn(outn97), .fin(fin97));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entered just after a rising edge with arm low; leaves in the same phase.
  task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic s1,
                      input logic s2, input logic [15:0] exp, input string tag);
    a1_8 = x; a2_8 = y; sg1 = s1; sg2 = s2; arm8 = 1'b1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1 check({tag, " fin_early"}, 64'(fin8), 64'd0);
    @(posedge clk);
    #1 check({tag, " fin"}, 64'(fin8), 64'd1);
    check({tag, " outn"}, 64'(outn8), 64'(exp));
    arm8 = 1'b0;
    @(posedge clk);
    #1 check({tag, " fin_drop"}, 64'(fin8), 64'd0);
  endtask

  task automatic run32(input logic [31:0] x, input logic [31:0] y, input logic s1,
                       input logic s2, input logic [63:0] exp, input string tag);
    a1_32 = x; a2_32 = y; sg1 = s1; sg2 = s2; arm32 = 1'b1;
    @(posedge clk);
    repeat (16) @(posedge clk);
    #1 check({tag, " fin_early"}, 64'(fin32), 64'd0);
    @(posedge clk);
    #1 check({tag, " fin"}, 64'(fin32), 64'd1);
    check({tag, " outn"}, outn32, exp);
    arm32 = 1'b0;
    @(posedge clk);
    #1 check({tag, " fin_drop"}, 64'(fin32), 64'd0);
  endtask

  initial begin
    logic [7:0]  r8a, r8b;
    logic [31:0] r32a, r32b;
    logic        rs1, rs2;
    longint      av, bv;

    rst_L = 1'b0; sg1 = 1'b0; sg2 = 1'b0;
    arm8 = 1'b0; a1_8 = '0; a2_8 = '0;
    arm32 = 1'b0; a1_32 = '0; a2_32 = '0;
    arm97 = 1'b0; a1_97 = '0; a2_97 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst fin8", 64'(fin8), 64'd0);
    check("rst outn8", 64'(outn8), 64'd0);
    check("rst fin32", 64'(fin32), 64'd0);
    check("rst outn32", outn32, 64'd0);
    rst_L = 1'b1;
    @(posedge clk);
    #1;

    // 8x8 directed vectors
    run8(8'h80, 8'h80, 1'b1, 1'b1, 16'h4000, "s-128x-128");
    run8(8'hFD, 8'h07, 1'b1, 1'b1, 16'hFFEB, "s-3x7");
    run8(8'hFF, 8'hFF, 1'b0, 1'b0, 16'hFE01, "u255x255");
    run8(8'h00, 8'hC8, 1'b0, 1'b0, 16'h0000, "u0x200");
    run8(8'hFF, 8'hFF, 1'b0, 1'b1, 16'hFF01, "mix_u255xs-1");
    run8(8'hFF, 8'hFF, 1'b1, 1'b0, 16'hFF01, "mix_s-1xu255");
    run8(8'h7F, 8'h80, 1'b1, 1'b1, 16'hC080, "s127x-128");

    // 9x7: odd multiplier width, ITER=4
    a1_97 = 9'h100; a2_97 = 7'h40; sg1 = 1'b1; sg2 = 1'b1; arm97 = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1 check("w97 fin_early", 64'(fin97), 64'd0);
    @(posedge clk);
    #1 check("w97 fin", 64'(fin97), 64'd1);
    check("w97 s-256x-64", 64'(outn97), 64'd16384);
    arm97 = 1'b0;
    @(posedge clk);
    #1 check("w97 fin_drop", 64'(fin97), 64'd0);
    a1_97 = 9'h1FF; a2_97 = 7'h7F; sg1 = 1'b0; sg2 = 1'b0; arm97 = 1'b1;
    repeat (5) @(posedge clk);
    #1 check("w97 u511x127", 64'(outn97), 64'h0000_0000_0000_FD81);
    arm97 = 1'b0;
    @(posedge clk);
    #1;

    // 32x32: complete, abort, hold in DONE
    run32(32'd7, 32'd6, 1'b0, 1'b0, 64'd42, "u7x6");
    a1_32 = 32'd5; a2_32 = 32'd5; arm32 = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1 arm32 = 1'b0;
    @(posedge clk);
    #1 check("abort fin", 64'(fin32), 64'd0);
    check("abort outn", outn32, 64'd42);
    repeat (20) @(posedge clk);
    #1 check("abort fin_late", 64'(fin32), 64'd0);
    check("abort outn_late", outn32, 64'd42);

    a1_32 = 32'hFFFF_FFFD; a2_32 = 32'd100; sg1 = 1'b1; sg2 = 1'b1; arm32 = 1'b1;
    @(posedge clk);
    repeat (17) @(posedge clk);
    #1 check("hold fin", 64'(fin32), 64'd1);
    check("hold outn", outn32, 64'hFFFF_FFFF_FFFF_FED4);
    a1_32 = 32'd1234; a2_32 = 32'd77;
    repeat (10) @(posedge clk);
    #1 check("hold fin_10", 64'(fin32), 64'd1);
    check("hold outn_10", outn32, 64'hFFFF_FFFF_FFFF_FED4);
    arm32 = 1'b0;
    @(posedge clk);
    #1 check("hold fin_drop", 64'(fin32), 64'd0);

    // Asynchronous reset between edges during RUN
    a1_32 = 32'd9; a2_32 = 32'd9; sg1 = 1'b0; sg2 = 1'b0; arm32 = 1'b1;
    @(posedge clk);
    repeat (2) @(posedge clk);
    #2 rst_L = 1'b0;
    #1 check("arst fin", 64'(fin32), 64'd0);
    check("arst outn", outn32, 64'd0);
    arm32 = 1'b0;
    @(posedge clk);
    #1 rst_L = 1'b1;
    @(posedge clk);
    #1;
    run32(32'd3, 32'd4, 1'b0, 1'b0, 64'd12, "post_rst 3x4");

    // Random sweep against a longint reference product
    for (int m = 0; m < 4; m++) begin
      rs1 = m[0]; rs2 = m[1];
      for (int k = 0; k < 100; k++) begin
        r8a = 8'($urandom); r8b = 8'($urandom);
        av = rs1 ? longint'($signed(r8a)) : longint'(r8a);
        bv = rs2 ? longint'($signed(r8b)) : longint'(r8b);
        run8(r8a, r8b, rs1, rs2, 16'(av * bv), $sformatf("rand8 m%0d %h*%h", m, r8a, r8b));
      end
      for (int k = 0; k < 40; k++) begin
        r32a = $urandom; r32b = $urandom;
        av = rs1 ? longint'($signed(r32a)) : longint'(r32a);
        bv = rs2 ? longint'($signed(r32b)) : longint'(r32b);
        run32(r32a, r32b, rs1, rs2, 64'(av * bv), $sformatf("rand32 m%0d %h*%h", m, r32a, r32b));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
